block_fetcher: RTL and testbench
================================

BLOCK_FETCHER -- requirements
Module: block_fetcher

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: bits per word.
REQ-002 SHALL have parameter EXTERNAL_ADDR_SIZE, default 16: external address width.
REQ-003 SHALL have parameter WORD_OFFSET, default 4: word-offset bits; NUM_OF_WORDS_IN_BLOCK equals 2**WORD_OFFSET.
REQ-004 SHALL have parameter NUM_OF_WORDS_IN_BLOCK, default 16: words per block.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port busy, input, 1 bit: miss request from the cache set.
REQ-008 SHALL have port r_requested_addr, input, EXTERNAL_ADDR_SIZE bits: miss address from the set.
REQ-009 SHALL have port mem_rd, output, 1 bit: one-cycle read strobe to backing memory.
REQ-010 SHALL have port mem_addr, output, EXTERNAL_ADDR_SIZE bits: word address for mem_rd.
REQ-011 SHALL have port mem_valid, input, 1 bit: mem_data is valid this cycle.
REQ-012 SHALL have port mem_data, input, WORD_SIZE bits: read data from memory.
REQ-013 SHALL have port new_word, output, 1 bit: one-cycle pulse, incoming_word is valid.
REQ-014 SHALL have port incoming_word, output, WORD_SIZE bits: the word just fetched.
REQ-015 SHALL have port block_ready, output, 1 bit: one-cycle pulse, incoming_block is complete.
REQ-016 SHALL have port incoming_block, output, NUM_OF_WORDS_IN_BLOCK*WORD_SIZE bits: word i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-017 SHALL have port fetching, output, 1 bit: high while a fetch is in progress.

Function
REQ-018 SHALL use FSM states IDLE, REQ, WAIT, DONE and RELEASE.
REQ-019 IDLE with busy=1 SHALL latch base = r_requested_addr with its low WORD_OFFSET bits zeroed, latch start offset (REQ-036), clear count, and go to REQ on the next cycle.
REQ-020 REQ SHALL assert mem_rd for exactly one cycle with mem_addr = base | ((start+count) mod NUM_OF_WORDS_IN_BLOCK), then go to WAIT.
REQ-021 WAIT SHALL hold until mem_valid=1; mem_valid in any other state SHALL be ignored.
REQ-022 On mem_valid in WAIT: store mem_data into the slot given by its word offset; drive incoming_word=mem_data with new_word=1 in the following cycle.
REQ-023 In that same transition, if count == NUM_OF_WORDS_IN_BLOCK-1 go to DONE, else increment count and go to REQ.
REQ-024 DONE SHALL pulse block_ready for exactly one cycle with incoming_block holding all words, then go to RELEASE.
REQ-025 incoming_block SHALL hold its contents until the next fetch writes a slot.
REQ-026 RELEASE with busy=0 SHALL go to IDLE.
REQ-027 RELEASE with busy=1 and the requested block address equal to base SHALL stay in RELEASE; no refetch.
REQ-028 RELEASE with busy=1 and a different block address SHALL behave as IDLE with busy=1.
REQ-029 fetching SHALL be 1 in REQ, WAIT and DONE, and 0 in IDLE and RELEASE.
REQ-030 Changes to busy or r_requested_addr during REQ, WAIT or DONE SHALL be ignored; the latched block completes.
REQ-031 Count SHALL be WORD_OFFSET bits wide, and the offset sum SHALL wrap modulo NUM_OF_WORDS_IN_BLOCK.
REQ-032 Minimum fetch latency SHALL be 2*NUM_OF_WORDS_IN_BLOCK+2 cycles from busy sampled to block_ready, with mem_valid one cycle after mem_rd.

Reset
REQ-033 When rst=0 at a clock edge, the FSM SHALL go to IDLE and count SHALL clear.
REQ-034 When rst=0 at a clock edge, mem_rd, new_word, block_ready, fetching, mem_addr, incoming_word and incoming_block SHALL be 0.
REQ-035 Reset asserted mid-fetch SHALL abandon the fetch with no block_ready pulse, and later mem_valid SHALL be ignored.

Configuration
REQ-036 With macro CRITICAL_WORD_FIRST_EN defined, start SHALL equal the requested word offset r_requested_addr[WORD_OFFSET-1:0], so the missed word is delivered first and the sequence wraps.
REQ-037 Without CRITICAL_WORD_FIRST_EN, start SHALL be 0 and words SHALL be fetched at offsets 0..NUM_OF_WORDS_IN_BLOCK-1 in order.

Verification
REQ-038 Defaults, memory returns data=addr one cycle after mem_rd; busy=1, addr=0x1234 -> mem_addr 0x1230..0x123F, 16 new_word pulses, block_ready at cycle 34, word5=0x1235.
REQ-039 Same stimulus with CRITICAL_WORD_FIRST_EN -> first mem_addr 0x1234, wraps 0x123F->0x1230, last 0x1233, and incoming_block is identical to REQ-038.
REQ-040 mem_valid held low for 10 cycles on word 3 -> FSM stays in WAIT, no new_word, and block_ready is delayed by 10 cycles.
REQ-041 rst=0 after word 7 -> all outputs 0 next cycle, no block_ready, and a fresh busy=1, addr=0x0040 fetch completes correctly.
REQ-042 busy held at 1 after block_ready with the same block -> no new mem_rd; then addr changes to 0x2000 -> fetch of 0x2000..0x200F starts.

Source files
------------

// File: rtl/block_fetcher.sv
// rtl/block_fetcher.sv - cache-miss block fetcher: reads one block word by word from backing memory
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   : the fetch starts at the missed word and wraps around the block
//   undefined : the fetch always runs from word 0 up to the last word
//
// Ports
//   clk              : clock, everything on the rising edge
//   rst              : synchronous active-low reset
//   busy             : miss request from the cache set
//   r_requested_addr : miss address from the set
//   mem_rd           : one-cycle read strobe to backing memory
//   mem_addr         : word address for mem_rd
//   mem_valid        : mem_data valid this cycle (only honoured while waiting)
//   mem_data         : read data from memory
//   new_word         : one-cycle pulse, incoming_word is valid
//   incoming_word    : the word just fetched
//   block_ready      : one-cycle pulse, incoming_block is complete
//   incoming_block   : assembled block, word i at [i*WORD_SIZE +: WORD_SIZE]
//   fetching         : high while a fetch is in progress

module block_fetcher #(
  parameter int WORD_SIZE             = 16,
  parameter int EXTERNAL_ADDR_SIZE    = 16,
  parameter int WORD_OFFSET           = 4,
  parameter int NUM_OF_WORDS_IN_BLOCK = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      busy,
  input  logic [EXTERNAL_ADDR_SIZE-1:0]             r_requested_addr,
  output logic                                      mem_rd,
  output logic [EXTERNAL_ADDR_SIZE-1:0]             mem_addr,
  input  logic                                      mem_valid,
  input  logic [WORD_SIZE-1:0]                      mem_data,
  output logic                                      new_word,
  output logic [WORD_SIZE-1:0]                      incoming_word,
  output logic                                      block_ready,
  output logic [NUM_OF_WORDS_IN_BLOCK*WORD_SIZE-1:0] incoming_block,
  output logic                                      fetching
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [EXTERNAL_ADDR_SIZE-1:0] BLOCK_MASK =
    {{(EXTERNAL_ADDR_SIZE-WORD_OFFSET){1'b1}}, {WORD_OFFSET{1'b0}}};
  localparam logic [WORD_OFFSET-1:0] LAST_COUNT = WORD_OFFSET'(NUM_OF_WORDS_IN_BLOCK-1);

  state_t state, state_next;

  logic [EXTERNAL_ADDR_SIZE-1:0] base;
  logic [WORD_OFFSET-1:0]        start;
  logic [WORD_OFFSET-1:0]        count;

  logic [EXTERNAL_ADDR_SIZE-1:0] req_block;
  logic [WORD_OFFSET-1:0]        req_start;
  logic [WORD_OFFSET-1:0]        cur_off;
  logic [WORD_OFFSET-1:0]        next_off;
  logic                          last_word;
  logic                          load;
  logic                          take;

  // Block-aligned request address; masking keeps every input bit in the
  // expression, the low bits simply fall away.
  assign req_block = r_requested_addr & BLOCK_MASK;

`ifdef CRITICAL_WORD_FIRST_EN
  assign req_start = r_requested_addr[WORD_OFFSET-1:0];
`else
  assign req_start = '0;
`endif

  // Offsets are WORD_OFFSET bits wide, so the sum wraps inside the block.
  assign cur_off   = start + count;
  assign next_off  = start + count + WORD_OFFSET'(1);
  assign last_word = (count == LAST_COUNT);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (busy) begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          take       = 1'b1;
          state_next = last_word ? DONE : REQ;
        end
      end
      DONE: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        // Holding busy on the block just delivered must not refetch it;
        // a different block is treated like a fresh miss from IDLE.
        if (!busy) begin
          state_next = IDLE;
        end else if (req_block != base) begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      base           <= '0;
      start          <= '0;
      count          <= '0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      new_word       <= 1'b0;
      incoming_word  <= '0;
      block_ready    <= 1'b0;
      incoming_block <= '0;
      fetching       <= 1'b0;
    end else begin
      state <= state_next;

      if (load) begin
        base  <= req_block;
        start <= req_start;
        count <= '0;
      end else if (take && !last_word) begin
        count <= count + WORD_OFFSET'(1);
      end

      // The read strobe and its address are registered together as the FSM
      // enters REQ, so the strobe lines up with the REQ cycle.
      mem_rd <= (state_next == REQ);
      if (load) begin
        mem_addr <= req_block | EXTERNAL_ADDR_SIZE'(req_start);
      end else if (take && !last_word) begin
        mem_addr <= base | EXTERNAL_ADDR_SIZE'(next_off);
      end

      new_word <= take;
      if (take) begin
        incoming_word <= mem_data;
      end

      for (int i = 0; i < NUM_OF_WORDS_IN_BLOCK; i++) begin
        if (take && (cur_off == WORD_OFFSET'(i))) begin
          incoming_block[i*WORD_SIZE +: WORD_SIZE] <= mem_data;
        end
      end

      block_ready <= (state == DONE);
      fetching    <= (state_next == REQ) || (state_next == WAIT) || (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_block_fetcher.sv
// tb/tb_block_fetcher.sv - scoreboard bench for block_fetcher with a reference model and memory model

module tb_block_fetcher;

  localparam int W  = 16;
  localparam int A  = 16;
  localparam int WO = 4;
  localparam int N  = 16;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          busy = 1'b0;
  logic [A-1:0]  r_requested_addr = '0;
  logic          mem_rd;
  logic [A-1:0]  mem_addr;
  logic          mem_valid = 1'b0;
  logic [W-1:0]  mem_data = '0;
  logic          new_word;
  logic [W-1:0]  incoming_word;
  logic          block_ready;
  logic [BW-1:0] incoming_block;
  logic          fetching;

  block_fetcher #(
    .WORD_SIZE(W), .EXTERNAL_ADDR_SIZE(A), .WORD_OFFSET(WO), .NUM_OF_WORDS_IN_BLOCK(N)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy), .r_requested_addr(r_requested_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .new_word(new_word), .incoming_word(incoming_word), .block_ready(block_ready),
    .incoming_block(incoming_block), .fetching(fetching)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Memory model controls, each written by the stimulus process only.
  logic [W-1:0] key = '0;
  int           stall_at = -1;
  int           stall_len = 0;
  logic         inject = 1'b0;
  int           rd_total = 0;

  // Scoreboard
  logic [A-1:0]  addr_q[$];
  logic [W-1:0]  word_q[$];
  logic [BW-1:0] blk_q[$];
  int nw_cnt = 0;
  int rd_cnt = 0;
  int rdy_cnt = 0;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, got, exp);
  endtask

  task automatic unexpected(input string name, input logic [BW-1:0] got);
    checks++;
    $display("FAIL %s unexpected output value=%0h required=no output", name, got);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: answers each read strobe one cycle later with data = addr ^ key,
  // optionally stalling on a chosen read; inject produces a stray mem_valid.
  initial forever begin
    logic [A-1:0] a;
    int           idx;
    int           extra;
    @(negedge clk);
    if (mem_rd || inject) begin
      a     = mem_addr;
      extra = 0;
      if (mem_rd) begin
        idx = rd_total;
        rd_total++;
        if (idx == stall_at) extra = stall_len;
      end
      repeat (extra) @(posedge clk);
      @(posedge clk);
      #1;
      mem_valid = 1'b1;
      mem_data  = a ^ key;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
    end
  end

  // Monitor: every output event is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (mem_rd) begin
      rd_cnt++;
      if (addr_q.size() == 0) unexpected("mem_rd", BW'(mem_addr));
      else check("mem_addr", BW'(mem_addr), BW'(addr_q.pop_front()));
    end
    if (new_word) begin
      nw_cnt++;
      if (word_q.size() == 0) unexpected("new_word", BW'(incoming_word));
      else check("incoming_word", BW'(incoming_word), BW'(word_q.pop_front()));
    end
    if (block_ready) begin
      rdy_cnt++;
      if (blk_q.size() == 0) unexpected("block_ready", incoming_block);
      else check("incoming_block", incoming_block, blk_q.pop_front());
    end
  end

  // Reference model: the block base is the address rounded down to a block,
  // words are visited from the start offset in wrapping order.
  task automatic push_expect(input logic [A-1:0] addr, output logic [BW-1:0] blk);
    int base;
    int s;
    int off;
    base = (int'(addr) / N) * N;
`ifdef CRITICAL_WORD_FIRST_EN
    s = int'(addr) % N;
`else
    s = 0;
`endif
    for (int i = 0; i < N; i++) begin
      off = (s + i) % N;
      addr_q.push_back(A'(base + off));
      word_q.push_back(W'(base + off) ^ key);
    end
    blk = '0;
    for (int j = 0; j < N; j++) blk[j*W +: W] = W'(base + j) ^ key;
    blk_q.push_back(blk);
  endtask

  task automatic do_fetch(input logic [A-1:0] addr, input bit scramble, input int stall_word,
                          input int slen, input bit hold, input int exp_lat,
                          output logic [BW-1:0] blk);
    int  drive_cyc;
    bit  seen;
    push_expect(addr, blk);
    @(posedge clk);
    #1;
    stall_at  = (stall_word < 0) ? -1 : rd_total + stall_word;
    stall_len = slen;
    busy = 1'b1;
    r_requested_addr = addr;
    drive_cyc = cyc;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (t == 5) check("fetching_mid", BW'(fetching), BW'(1));
      if (block_ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (scramble) begin
        busy = 1'($urandom);
        r_requested_addr = A'($urandom);
      end
    end
    if (hold) begin
      busy = 1'b1;
      r_requested_addr = addr;
    end else begin
      busy = 1'b0;
    end
    if (!seen) begin
      checks++;
      $display("FAIL fetch_timeout actual=no block_ready required=block_ready addr=%0h", addr);
    end else begin
      // Cycle in which busy was first presented counts as cycle 0.
      check("latency", BW'(cyc - drive_cyc), BW'(exp_lat));
      check("fetching_release", BW'(fetching), BW'(0));
      check("words_left", BW'(word_q.size() + addr_q.size()), BW'(0));
    end
    stall_at = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd"}, BW'(mem_rd), BW'(0));
    check({tag, "_new_word"}, BW'(new_word), BW'(0));
    check({tag, "_block_ready"}, BW'(block_ready), BW'(0));
    check({tag, "_fetching"}, BW'(fetching), BW'(0));
    check({tag, "_mem_addr"}, BW'(mem_addr), BW'(0));
    check({tag, "_incoming_word"}, BW'(incoming_word), BW'(0));
    check({tag, "_incoming_block"}, incoming_block, BW'(0));
  endtask

  initial begin
    logic [BW-1:0] blk;
    logic [BW-1:0] blk_hold;
    int n0;
    int r0;
    int k0;
    bit hit;

    rst  = 1'b0;
    busy = 1'b1;
    r_requested_addr = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    busy = 1'b0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);

    // Directed miss at 0x1234 with data = addr.
    key = '0;
    do_fetch(16'h1234, 1'b0, -1, 0, 1'b0, 34, blk);
    check("word5", BW'(incoming_block[5*W +: W]), BW'(16'h1235));
    repeat (6) @(posedge clk);
    #1;
    check("block_held", incoming_block, blk);

    // Memory stalls 10 cycles on word 3.
    key = 16'h5A5A;
    do_fetch(16'h3C07, 1'b0, 3, 10, 1'b0, 44, blk);

    // Reset after word 7, stray mem_valid afterwards, then a fresh fetch.
    key = 16'h0F0F;
    push_expect(16'h7777, blk);
    @(posedge clk);
    #1;
    busy = 1'b1;
    r_requested_addr = 16'h7777;
    n0 = nw_cnt;
    r0 = rdy_cnt;
    hit = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (nw_cnt - n0 >= 8) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      $display("FAIL reset_wait actual=%0d words required=8 words", nw_cnt - n0);
    end
    rst  = 1'b0;
    busy = 1'b0;
    addr_q.delete();
    word_q.delete();
    blk_q.delete();
    @(posedge clk);
    #1;
    check_outputs_zero("abort");
    rst = 1'b1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_words", BW'(nw_cnt - n0), BW'(8));
    check("abort_no_ready", BW'(rdy_cnt - r0), BW'(0));
    key = '0;
    do_fetch(16'h0040, 1'b0, -1, 0, 1'b0, 34, blk);

    // Busy held on the delivered block, then on another word of it: no refetch.
    key = 16'h1111;
    do_fetch(16'h1234, 1'b0, -1, 0, 1'b1, 34, blk_hold);
    k0 = rd_cnt;
    repeat (20) @(posedge clk);
    #1;
    r_requested_addr = 16'h123B;
    repeat (10) @(posedge clk);
    #1;
    check("hold_no_rd", BW'(rd_cnt - k0), BW'(0));
    check("hold_fetching", BW'(fetching), BW'(0));
    check("hold_block", incoming_block, blk_hold);
    key = '0;
    do_fetch(16'h2000, 1'b0, -1, 0, 1'b0, 34, blk);
    repeat (3) @(posedge clk);

    // Random misses with input scrambling during the fetch and random stalls.
    for (int i = 0; i < 8; i++) begin
      int sl;
      int sw;
      key = W'($urandom);
      sl  = $urandom_range(1, 5);
      sw  = $urandom_range(0, N - 1);
      do_fetch(A'($urandom), 1'b1, sw, sl, 1'b0, 34 + sl, blk);
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_queues", BW'(addr_q.size() + word_q.size() + blk_q.size()), BW'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
